// File: rtl/phy_tx_lanes.sv
// Two-lane transmit PHY: stripes accepted 32-bit words alternately across two
// serial lanes, sending COM/idle symbols when no data is pending. Optional macro: PHY_TX_STATS_EN.

// One serial lane. At a frame boundary it loads a data word, or idle symbols when
// there is no word. Between boundaries it shifts the word out MSB-first.
module phy_tx_lane #(
    parameter logic [7:0] IDLE_SYM = 8'hBC
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        i_bound,
    input  logic        i_load,
    input  logic [31:0] i_word,
    output logic        o_bit,
    output logic        o_vld
);
    logic [31:0] r_sh;
    logic        r_flag;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_sh   <= {4{IDLE_SYM}};
            r_flag <= 1'b0;
        end else if (i_bound) begin
            r_sh   <= i_load ? i_word : {4{IDLE_SYM}};
            r_flag <= i_load;
        end else begin
            r_sh   <= r_sh << 1;
        end
    end

    assign o_bit = r_sh[31];
    assign o_vld = r_flag;
endmodule

module phy_tx_lanes #(
    parameter logic [7:0] IDLE_SYM        = 8'hBC,
    parameter int         MIN_IDLE_FRAMES = 1
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_in,
    output logic        data_out_0,
    output logic        data_out_1,
    output logic        valid_out_0,
`ifdef PHY_TX_STATS_EN
    output logic        valid_out_1,
    output logic [15:0] tx_word_count
`else
    output logic        valid_out_1
`endif
);
    localparam logic [3:0] IDLE_LIM = 4'(MIN_IDLE_FRAMES - 1);

    logic [4:0]       r_frame_cnt;
    logic [1:0][31:0] r_fifo;
    logic [1:0]       r_count;
    logic             r_next_lane;
    logic [3:0]       r_idle_cnt;

    logic             w_bound;
    logic             w_idle;
    logic             w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_rem;
    logic [1:0]       w_load;
    logic [1:0][31:0] w_word;
    logic [1:0]       w_bits;
    logic [1:0]       w_vld;

    assign w_bound  = (r_frame_cnt == 5'd31);
    assign w_idle   = (r_idle_cnt < IDLE_LIM);
    assign ready_in = (r_count != 2'd2);
    assign w_push   = valid_in && ready_in;
    // Pop uses the count before this cycle's push, so a word accepted on the
    // boundary cycle waits for the next boundary.
    assign w_pop    = (w_bound && !w_idle) ? r_count : 2'd0;
    assign w_rem    = r_count - w_pop;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= 5'd0;
            r_fifo      <= '0;
            r_count     <= 2'd0;
            r_next_lane <= 1'b0;
            r_idle_cnt  <= 4'd0;
        end else begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
            r_count     <= w_rem + {1'b0, w_push};
            r_next_lane <= r_next_lane ^ w_pop[0];
            if (w_pop == 2'd1)
                r_fifo[0] <= r_fifo[1];
            if (w_push)
                r_fifo[w_rem[0]] <= data_in;
            if (w_bound && w_idle)
                r_idle_cnt <= r_idle_cnt + 4'd1;
        end
    end

`ifdef PHY_TX_STATS_EN
    logic [15:0] r_tx_word_count;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset)
            r_tx_word_count <= 16'd0;
        else if (w_bound)
            r_tx_word_count <= r_tx_word_count + {14'd0, w_pop};
    end

    assign tx_word_count = r_tx_word_count;
`endif

    // Oldest word goes to next_lane; a second word fills the other lane.
    for (genvar L = 0; L < 2; L++) begin : g_lane
        assign w_word[L] = (r_next_lane == 1'(L)) ? r_fifo[0] : r_fifo[1];
        assign w_load[L] = (r_next_lane == 1'(L)) ? (w_pop != 2'd0) : (w_pop == 2'd2);

        phy_tx_lane #(.IDLE_SYM(IDLE_SYM)) u_lane (
            .clk_32f (clk_32f),
            .reset   (reset),
            .i_bound (w_bound),
            .i_load  (w_load[L]),
            .i_word  (w_word[L]),
            .o_bit   (w_bits[L]),
            .o_vld   (w_vld[L])
        );
    end

    assign data_out_0  = w_bits[0];
    assign data_out_1  = w_bits[1];
    assign valid_out_0 = w_vld[0];
    assign valid_out_1 = w_vld[1];
endmodule

// File: tb/tb_phy_tx_lanes.sv
// Randomized bench for phy_tx_lanes against a frame-level queue model of the lanes.
module tb_phy_tx_lanes;
    logic        clk_32f = 1'b0;
    logic        reset   = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] data_in  = 32'd0;

    logic ready_a, d0_a, d1_a, v0_a, v1_a;
    logic ready_b, d0_b, d1_b, v0_b, v1_b;
`ifdef PHY_TX_STATS_EN
    logic [15:0] cnt_a, cnt_b;
`endif

    phy_tx_lanes dut_a (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_a), .data_out_0(d0_a), .data_out_1(d1_a),
        .valid_out_0(v0_a),
`ifdef PHY_TX_STATS_EN
        .valid_out_1(v1_a), .tx_word_count(cnt_a)
`else
        .valid_out_1(v1_a)
`endif
    );

    phy_tx_lanes #(.MIN_IDLE_FRAMES(3)) dut_b (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_b), .data_out_0(d0_b), .data_out_1(d1_b),
        .valid_out_0(v0_b),
`ifdef PHY_TX_STATS_EN
        .valid_out_1(v1_b), .tx_word_count(cnt_b)
`else
        .valid_out_1(v1_b)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    // Reference model: t = cycles since reset release, a queue of pending words,
    // and the word (or idle) each lane is sending this frame.
    logic [31:0] mq[$];
    int          t;
    logic        nl;
    logic [1:0]  lane_vld;
    logic [31:0] lane_word[2];
    logic [31:0] idle_w = 32'hBCBCBCBC;
    int          min_idle = 1;
    int          sel = 0;
    int          popped;
    logic        last_acc;
    int          n_pass = 0;
    int          n_checks = 0;

    function automatic logic [4:0] exp_vec();
        int p;
        logic [31:0] w0, w1;
        p  = t % 32;
        w0 = lane_vld[0] ? lane_word[0] : idle_w;
        w1 = lane_vld[1] ? lane_word[1] : idle_w;
        return {w1[31-p], w0[31-p], lane_vld[1], lane_vld[0], mq.size() < 2};
    endfunction

    function automatic logic [4:0] act_vec();
        if (sel != 0) return {d1_b, d0_b, v1_b, v0_b, ready_b};
        return {d1_a, d0_a, v1_a, v0_a, ready_a};
    endfunction

    task automatic model_reset();
        mq.delete();
        t = 0; nl = 1'b0; lane_vld = 2'b00; popped = 0;
        lane_word[0] = 32'd0; lane_word[1] = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        reset = 1'b0; valid_in = 1'b0;
        @(negedge clk_32f);
        reset = 1'b1;
        model_reset();
    endtask

    // Drive one cycle and advance the model; returns at the following negedge.
    task automatic tick(input logic v, input logic [31:0] d);
        logic acc;
        valid_in = v; data_in = d;
        acc = v && (mq.size() < 2);
        @(posedge clk_32f);
        if (t % 32 == 31) begin
            lane_vld = 2'b00;
            if (t / 32 >= min_idle - 1) begin
                for (int k = 0; k < 2; k++) begin
                    if (mq.size() > 0) begin
                        lane_word[nl] = mq.pop_front();
                        lane_vld[nl]  = 1'b1;
                        nl = ~nl;
                        popped++;
                    end
                end
            end
        end
        if (acc) mq.push_back(d);
        t++;
        last_acc = acc;
        @(negedge clk_32f);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 45; i++) begin
            tick(1'($urandom_range(0, 1)), $urandom);
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL reset_pre t=%0d got %b want %b", t, act_vec(), exp_vec());
            else n_pass++;
        end
        reset = 1'b0; valid_in = 1'b0;
        #1;
        n_checks++;
        if (act_vec() !== 5'b11001) $display("FAIL reset_async got %b want %b", act_vec(), 5'b11001);
        else n_pass++;
        @(negedge clk_32f);
        n_checks++;
        if (act_vec() !== 5'b11001) $display("FAIL reset_held got %b want %b", act_vec(), 5'b11001);
        else n_pass++;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 32'd0);
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL reset_idle t=%0d got %b want %b", t, act_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_single_word();
        do_reset();
        while (t != 37) begin
            tick(1'b0, 32'd0);
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL single_pre t=%0d got %b want %b", t, act_vec(), exp_vec());
            else n_pass++;
        end
        tick(1'b1, 32'h11223344);
        while (t < 100) begin
            tick(1'b0, 32'd0);
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL single t=%0d got %b want %b", t, act_vec(), exp_vec());
            else n_pass++;
            if (t == 64) begin
                n_checks++;
                if ({v1_a, v0_a} !== 2'b01) $display("FAIL single_lane0 got %b want 01", {v1_a, v0_a});
                else n_pass++;
            end
        end
        tick(1'b1, 32'h55667788);
        while (t < 200) begin
            tick(1'b0, 32'd0);
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL single_next t=%0d got %b want %b", t, act_vec(), exp_vec());
            else n_pass++;
            if (t == 140) begin
                n_checks++;
                if ({v1_a, v0_a} !== 2'b10) $display("FAIL single_lane1 got %b want 10", {v1_a, v0_a});
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[4];
        int idx;
        words[0] = 32'hDEADBEEF; words[1] = 32'h0000FFFF;
        words[2] = 32'hA5A5A5A5; words[3] = 32'h01020304;
        idx = 0;
        do_reset();
        for (int i = 0; i < 180; i++) begin
            tick(idx < 4, (idx < 4) ? words[idx] : 32'd0);
            if (last_acc) idx++;
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL b2b t=%0d got %b want %b", t, act_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_boundary_push();
        do_reset();
        while (t != 63) begin
            tick(1'b0, 32'd0);
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL bpush_pre t=%0d got %b want %b", t, act_vec(), exp_vec());
            else n_pass++;
        end
        tick(1'b1, 32'h9ABCDEF0);
        while (t < 140) begin
            tick(1'b0, 32'd0);
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL bpush t=%0d got %b want %b", t, act_vec(), exp_vec());
            else n_pass++;
            if (t == 80 || t == 100) begin
                n_checks++;
                if (v0_a !== (t == 100)) $display("FAIL bpush_valid t=%0d got %b want %b", t, v0_a, t == 100);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            tick(1'($urandom_range(0, 2) != 0), $urandom);
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL random t=%0d got %b want %b", t, act_vec(), exp_vec());
            else n_pass++;
`ifdef PHY_TX_STATS_EN
            n_checks++;
            if (cnt_a !== 16'(popped)) $display("FAIL stats t=%0d got %0d want %0d", t, cnt_a, 16'(popped));
            else n_pass++;
`endif
        end
    endtask

    task automatic test_forced_idle();
        sel = 1; min_idle = 3;
        do_reset();
        tick(1'b1, 32'hCAFEF00D);
        while (t < 170) begin
            tick(1'b0, 32'd0);
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL fidle t=%0d got %b want %b", t, act_vec(), exp_vec());
            else n_pass++;
            if (t == 95 || t == 96) begin
                n_checks++;
                if (v0_b !== (t == 96)) $display("FAIL fidle_valid t=%0d got %b want %b", t, v0_b, t == 96);
                else n_pass++;
            end
        end
        sel = 0; min_idle = 1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_boundary_push();
        test_random();
        test_forced_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/phy_tx_lanes.md
Name: phy_tx_lanes

Overview:
- Transmit-side PHY block: accepts 32-bit words over a valid/ready handshake, stripes whole words alternately onto two serial lanes, and serializes each lane MSB-first, one bit per clk_32f.
- Lanes carry the COM symbol when no data is pending, so the receive-side serial-to-parallel stages can byte-align and flag valid data.
- Single clock domain; byte and word framing come from internal counters, not derived clocks.

Parameters:
- IDLE_SYM, 8'hBC, COM/idle byte sent on a lane with no data word.
- MIN_IDLE_FRAMES, 1, number of 32-bit frames, frame 0 included, forced idle on both lanes after reset before any data word is loaded (1..15).

Ports:
- clk_32f  in  1  bit clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  32  word to transmit.
- valid_in  in  1  data_in valid.
- ready_in  out  1  block can accept a word this cycle.
- data_out_0  out  1  lane 0 serial bit.
- data_out_1  out  1  lane 1 serial bit.
- valid_out_0  out  1  high while lane 0 carries a data word (not idle).
- valid_out_1  out  1  high while lane 1 carries a data word.

Behaviour:
- State: frame_cnt[4:0] (0..31, wraps); 2-entry input FIFO with count 0..2; next_lane pointer; idle_cnt; per-lane 32-bit shift register sh_N; per-lane data flag.
- Reset (reset=0, async):
  - frame_cnt=0, FIFO count=0, next_lane=0, idle_cnt=0.
  - sh_N={4{IDLE_SYM}}, flags=0.
  - Result: data_out_N=1 (bit 7 of 8'hBC), valid_out_N=0, ready_in=1.
- Outputs: data_out_N = sh_N[31]; valid_out_N = lane data flag; no combinational path from inputs to outputs.
- Handshake:
  - ready_in = (count<2), a function of registered state only.
  - Transfer occurs when valid_in & ready_in.
  - data_in is ignored when ready_in=0.
  - Words leave the FIFO in acceptance order.
- Shift: every cycle with frame_cnt!=31, sh_N <= sh_N<<1.
- Frame boundary (cycle with frame_cnt==31):
  - If idle_cnt < MIN_IDLE_FRAMES-1: idle_cnt++, both lanes reload {4{IDLE_SYM}}, flags=0, no pop.
  - Otherwise, pop p = min(count,2) words, oldest first:
    - First popped word goes to lane next_lane; second to the other lane.
    - Each loaded lane gets flag=1; any lane not loaded reloads {4{IDLE_SYM}} with flag=0.
    - next_lane toggles once per popped word (p=2 leaves it unchanged).
  - Words accepted in the frame_cnt==31 cycle are not eligible for that boundary (no bypass).
  - Count update: count_next = count - p + push; a push lands in the slot freed that cycle.
- Latency: word accepted with an empty FIFO at frame_cnt=k appears MSB-first starting the cycle after the next frame_cnt==31 edge; its last bit is 32 cycles later.
- Sustained throughput: 2 words / 32 cycles. With valid_in held high, ready_in never stalls more than 31 cycles.
- Bit order: byte 3 (data[31:24]) first, each byte MSB first, so the receive side sees bytes in order [31:24],[23:16],[15:8],[7:0].
- Reset mid-frame: frame, FIFO and lane contents are discarded immediately; the idle sequence restarts after reset release.

Optional Feature:
- Macro: PHY_TX_STATS_EN.
- With macro: adds output port tx_word_count[15:0], reset 0, incremented by p at each frame boundary that pops words; wraps 16'hFFFF+1 -> 0 (and 16'hFFFF+2 -> 1).
- Without macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert reset=0 mid-frame, release -> data_out_0/1=1, valid_out=0, ready_in=1; both lanes emit 8'hBC x4 for frame 0 (bits 1,0,1,1,1,1,0,0 repeating).
- Single word: push 32'h11223344 at frame_cnt=5 in frame 1 -> from frame 2, lane 0 emits 8'h11,8'h22,8'h33,8'h44 MSB-first with valid_out_0=1; lane 1 emits 8'hBC x4 with valid_out_1=0; the next word then goes to lane 1.
- Back-to-back: hold valid_in with words A=32'hDEADBEEF, B=32'h0000FFFF, C=32'hA5A5A5A5, D=32'h01020304 -> lane 0 sends A then C, lane 1 sends B then D, same frames; ready_in deasserts while count=2.
- Boundary push: push a word in a frame_cnt==31 cycle with count=0 -> lanes idle for the following frame; the word transmits in the frame after that.
- Forced idle: MIN_IDLE_FRAMES=3, push 32'hCAFEF00D immediately after reset -> idle for frames 0-2; data appears on lane 0 at frame 3.
- Stats (PHY_TX_STATS_EN): preload 16'hFFFF via 65535 pushes (or force), send 2 words -> tx_word_count wraps to 16'h0001.
